mod1_unpacker: RTL and testbench



---
 rtl/mod1_unpacker.sv | 94 +++++++++
 tb/tb_mod1_unpacker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mod1_unpacker.sv
// mod1_unpacker: buffers 4-bit packed words and splits each into a flag bit and a 3-bit vector.
// Latency: a word accepted into an empty FIFO is presented one cycle later (no bypass path).
// Backpressure: OB_READY is low at DEPTH entries; words offered while full are dropped and set sticky OB_OVF.
// Optional build macro MOD1_UNPACK_STATS_EN adds OV_WORDS, an 8-bit wrapping count of completed pops.
module mod1_unpacker #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [3:0]    IV1_3,
   input  logic          IB_VALID,
   output logic          OB_READY,
   input  logic          IB_FLUSH,
   output logic          OB1,
   output logic [2:0]    OV2_2,
   output logic          OB_VALID,
   input  logic          IB_READY,
   output logic [CW-1:0] OV_COUNT,
   output logic          OB_OVF
`ifdef MOD1_UNPACK_STATS_EN
   ,
   output logic [7:0]    OV_WORDS
`endif
);

   // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
   localparam int AW = $clog2(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic [3:0]    head;

   // Handshake flags come from the registered count only, so OB_READY never
   // depends on IB_READY and a same-cycle push+pop while full cannot happen.
   assign OB_READY = (count != CW'(DEPTH));
   assign OB_VALID = (count != '0);
   assign push     = IB_VALID && OB_READY;
   assign pop      = OB_VALID && IB_READY;
   assign OV_COUNT = count;

   // Head entry is split into its fields; fields read as zero when empty.
   assign head  = mem[rptr];
   assign OB1   = OB_VALID ? head[3]   : 1'b0;
   assign OV2_2 = OB_VALID ? head[2:0] : 3'b000;

   // Storage write; the array itself is not reset, and flush/reset discard the word.
   always_ff @(posedge CLK) begin
      if (!RST && !IB_FLUSH && push) begin
         mem[wptr] <= IV1_3;
      end
   end

   // Pointer, occupancy and overflow tracking; flush outranks push and pop.
   always_ff @(posedge CLK) begin
      if (RST || IB_FLUSH) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         OB_OVF <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (IB_VALID && !OB_READY) begin
            OB_OVF <= 1'b1;
         end
      end
   end

`ifdef MOD1_UNPACK_STATS_EN
   // Completed-pop counter; wraps 255 -> 0 and clears with the FIFO.
   always_ff @(posedge CLK) begin
      if (RST || IB_FLUSH) begin
         OV_WORDS <= 8'd0;
      end else if (pop) begin
         OV_WORDS <= OV_WORDS + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mod1_unpacker.sv
// Bench for mod1_unpacker: directed stimulus with a scoreboard queue of expected words.
// Stimulus pushes expected words when a push is accepted; a negedge monitor pops and compares.
// Directed checks after selected edges use hand-computed constants.
module tb_mod1_unpacker;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          CLK = 1'b0;
   logic          RST;
   logic [3:0]    IV1_3;
   logic          IB_VALID;
   logic          OB_READY;
   logic          IB_FLUSH;
   logic          OB1;
   logic [2:0]    OV2_2;
   logic          OB_VALID;
   logic          IB_READY;
   logic [CW-1:0] OV_COUNT;
   logic          OB_OVF;
`ifdef MOD1_UNPACK_STATS_EN
   logic [7:0]    OV_WORDS;
`endif

   int total = 0;
   int bad   = 0;

   logic [3:0] sb_q [$];
   int         mcnt = 0;
   logic       movf = 1'b0;

   mod1_unpacker #(.DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IV1_3    (IV1_3),
      .IB_VALID (IB_VALID),
      .OB_READY (OB_READY),
      .IB_FLUSH (IB_FLUSH),
      .OB1      (OB1),
      .OV2_2    (OV2_2),
      .OB_VALID (OB_VALID),
      .IB_READY (IB_READY),
      .OV_COUNT (OV_COUNT),
      .OB_OVF   (OB_OVF)
`ifdef MOD1_UNPACK_STATS_EN
      ,
      .OV_WORDS (OV_WORDS)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the bench model is advanced at the edge.
   task automatic step(input logic v, input logic [3:0] d, input logic rdy,
                       input logic fl, input logic rs);
      logic pop_ok;
      logic push_ok;
      IB_VALID = v;
      IV1_3    = d;
      IB_READY = rdy;
      IB_FLUSH = fl;
      RST      = rs;
      @(posedge CLK);
      if (rs || fl) begin
         sb_q.delete();
         mcnt = 0;
         movf = 1'b0;
      end else begin
         pop_ok  = (mcnt != 0) && rdy;
         push_ok = v && (mcnt != DEPTH);
         if (v && !push_ok) movf = 1'b1;
         if (push_ok) sb_q.push_back(d);
         mcnt = mcnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
      end
      #1;
   endtask

   // Monitor: compare the presented head and flags against the scoreboard.
   always @(negedge CLK) begin
      chk("mon_valid", {31'd0, OB_VALID}, {31'd0, sb_q.size() != 0});
      if (sb_q.size() != 0) begin
         chk("mon_word", {28'd0, OB1, OV2_2}, {28'd0, sb_q[0]});
         if (IB_READY) void'(sb_q.pop_front());
      end else begin
         chk("mon_idle_word", {28'd0, OB1, OV2_2}, 32'd0);
      end
      chk("mon_count", 32'(OV_COUNT), 32'(mcnt));
      chk("mon_ready", {31'd0, OB_READY}, {31'd0, mcnt != DEPTH});
      chk("mon_ovf", {31'd0, OB_OVF}, {31'd0, movf});
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ob1s;
      logic [3:0] fill [4];
      ob1s = 4'b0110;
      fill[0] = 4'h3; fill[1] = 4'h8; fill[2] = 4'hF; fill[3] = 4'h0;

      // Reset state
      step(0, 4'h0, 0, 0, 1);
      step(0, 4'h0, 0, 0, 1);
      step(0, 4'h0, 0, 0, 0);
      chk("rst_valid", {31'd0, OB_VALID}, 32'd0);
      chk("rst_ready", {31'd0, OB_READY}, 32'd1);
      chk("rst_ob1",   {31'd0, OB1},      32'd0);
      chk("rst_ov2",   {29'd0, OV2_2},    32'd0);
      chk("rst_count", 32'(OV_COUNT),     32'd0);
      chk("rst_ovf",   {31'd0, OB_OVF},   32'd0);

      // Single word, one-cycle latency, then drained
      step(1, 4'b1101, 1, 0, 0);
      chk("one_valid", {31'd0, OB_VALID}, 32'd1);
      chk("one_ob1",   {31'd0, OB1},      32'd1);
      chk("one_ov2",   {29'd0, OV2_2},    32'd5);
      chk("one_count", 32'(OV_COUNT),     32'd1);
      step(0, 4'h0, 1, 0, 0);
      chk("one_gone_valid", {31'd0, OB_VALID}, 32'd0);
      chk("one_gone_ob1",   {31'd0, OB1},      32'd0);
      chk("one_gone_ov2",   {29'd0, OV2_2},    32'd0);

      // Fill to full, overflow, then drain in order
      for (int i = 0; i < 4; i++) step(1, fill[i], 0, 0, 0);
      chk("full_count", 32'(OV_COUNT),     32'd4);
      chk("full_ready", {31'd0, OB_READY}, 32'd0);
      step(1, 4'h7, 0, 0, 0);
      chk("ovf_set",   {31'd0, OB_OVF},   32'd1);
      chk("ovf_count", 32'(OV_COUNT),     32'd4);
      chk("ovf_head",  {29'd0, OV2_2},    32'd3);
      for (int i = 0; i < 4; i++) begin
         chk("drain_ob1", {31'd0, OB1}, {31'd0, ob1s[i]});
         step(0, 4'h0, 1, 0, 0);
      end
      chk("drain_count",  32'(OV_COUNT),   32'd0);
      chk("ovf_sticky",   {31'd0, OB_OVF}, 32'd1);
      step(0, 4'h0, 0, 1, 0);

      // Steady occupancy of 2 with simultaneous push/pop; pointers wrap
      step(1, 4'hA, 0, 0, 0);
      step(1, 4'hB, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         step(1, 4'(i), 1, 0, 0);
         chk("hold_count", 32'(OV_COUNT), 32'd2);
      end
      step(0, 4'h0, 1, 0, 0);
      step(0, 4'h0, 1, 0, 0);
      chk("hold_drained", 32'(OV_COUNT), 32'd0);

      // Flush with 3 words held, overflow set, and a push offered
      for (int i = 0; i < 5; i++) step(1, 4'(4'hC + 4'(i)), 0, 0, 0);
      step(0, 4'h0, 1, 0, 0);
      chk("pre_flush_count", 32'(OV_COUNT),   32'd3);
      chk("pre_flush_ovf",   {31'd0, OB_OVF}, 32'd1);
      step(1, 4'hE, 0, 1, 0);
      chk("flush_count", 32'(OV_COUNT),     32'd0);
      chk("flush_valid", {31'd0, OB_VALID}, 32'd0);
      chk("flush_ovf",   {31'd0, OB_OVF},   32'd0);
      chk("flush_ready", {31'd0, OB_READY}, 32'd1);
      step(0, 4'h0, 0, 0, 0);
      chk("flush_no_word", {31'd0, OB_VALID}, 32'd0);

      // Reset mid-transfer, then a clean word afterwards
      step(1, 4'h1, 0, 0, 0);
      step(1, 4'h2, 0, 0, 0);
      step(1, 4'h4, 0, 0, 1);
      chk("mid_rst_valid", {31'd0, OB_VALID}, 32'd0);
      chk("mid_rst_count", 32'(OV_COUNT),     32'd0);
      chk("mid_rst_ready", {31'd0, OB_READY}, 32'd1);
      chk("mid_rst_word",  {28'd0, OB1, OV2_2}, 32'd0);
      step(1, 4'h9, 0, 0, 0);
      chk("post_rst_ob1", {31'd0, OB1},   32'd1);
      chk("post_rst_ov2", {29'd0, OV2_2}, 32'd1);
      step(0, 4'h0, 1, 0, 0);

`ifdef MOD1_UNPACK_STATS_EN
      // 257 completed pops wrap the word counter to 1
      step(0, 4'h0, 0, 1, 0);
      chk("words_clear0", 32'(OV_WORDS), 32'd0);
      step(1, 4'h5, 0, 0, 0);
      for (int i = 0; i < 256; i++) step(1, 4'(i), 1, 0, 0);
      step(0, 4'h0, 1, 0, 0);
      chk("words_wrap", 32'(OV_WORDS), 32'd1);
      step(0, 4'h0, 0, 1, 0);
      chk("words_flush", 32'(OV_WORDS), 32'd0);
`endif

      step(0, 4'h0, 1, 0, 0);
      step(0, 4'h0, 1, 0, 0);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
